// File: rtl/nv_nvdla_cacc_psum_accum.sv
// Partial-sum accumulator behind CMAC: sums per-lane MAC results across channel groups in a
// stripe buffer and emits finished atoms through a small valid/ready output FIFO.
module nv_nvdla_cacc_psum_accum #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned IN_W       = 19,
  parameter int unsigned ACC_W      = 34,
  parameter int unsigned STRIPE_MAX = 32,
  parameter int unsigned OUT_DEPTH  = 4
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     mac2accu_pvld,
  input  logic [LANES-1:0]         mac2accu_mask,
  input  logic                     mac2accu_mode,
  input  logic [LANES*IN_W-1:0]    mac2accu_data,
  input  logic [8:0]               mac2accu_pd,
  output logic                     acc2out_pvld,
  input  logic                     acc2out_prdy,
  output logic [LANES*ACC_W-1:0]   acc2out_data,
  output logic [LANES-1:0]         acc2out_mask,
  output logic                     acc2out_layer_end,
  input  logic                     err_clr,
  output logic                     err_fifo_ovf,
  output logic                     err_stripe_ovf,
  output logic                     err_mode
);

  localparam int unsigned IdxW  = (STRIPE_MAX > 1) ? $clog2(STRIPE_MAX) : 1;
  localparam int unsigned PtrW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned DataW = LANES * ACC_W;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t IdxLast = idx_t'(STRIPE_MAX - 1);
  localparam ptr_t PtrLast = ptr_t'(OUT_DEPTH - 1);
  localparam cnt_t CntFull = cnt_t'(OUT_DEPTH);

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [IN_W-1:0]  b);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b});
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrLast) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  logic beat_st, beat_se, beat_ce, beat_le;
  logic unused_pd;
  assign beat_st   = mac2accu_pd[0];
  assign beat_se   = mac2accu_pd[1];
  assign beat_ce   = mac2accu_pd[2];
  assign beat_le   = mac2accu_pd[3];
  assign unused_pd = ^mac2accu_pd[8:4];

  // Stripe position tracking
  idx_t atom_idx_q, atom_idx_d, cur_idx;
  logic first_grp_q, first_grp_d;
  logic stripe_ovf;

  assign cur_idx = beat_st ? '0 : atom_idx_q;

  always_comb begin
    atom_idx_d  = atom_idx_q;
    first_grp_d = first_grp_q;
    stripe_ovf  = 1'b0;
    if (mac2accu_pvld) begin
      if (beat_se) begin
        atom_idx_d  = '0;
        first_grp_d = beat_ce;
      end else if (cur_idx == IdxLast) begin
        atom_idx_d = '0;
        stripe_ovf = 1'b1;
      end else begin
        atom_idx_d = idx_t'(cur_idx + 1'b1);
      end
    end
  end

  // S1 registers
  logic                  s1_vld_q, s1_ce_q, s1_le_q, s1_first_q;
  idx_t                  s1_idx_q;
  logic [LANES-1:0]      s1_mask_q;
  logic [LANES*IN_W-1:0] s1_data_q;
  logic [DataW-1:0]      s1_op_q, s1_op_d;
  logic [DataW-1:0]      stripe_mem_q [STRIPE_MAX];

  // S2 datapath
  logic [DataW-1:0] sum_vec;
  logic             wr_en, push;

  assign wr_en = s1_vld_q && !s1_ce_q;
  assign push  = s1_vld_q && s1_ce_q;

  always_comb begin
    logic [IN_W-1:0]  in_l;
    logic [ACC_W-1:0] op_l;
    sum_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      in_l = s1_mask_q[i] ? s1_data_q[i*IN_W +: IN_W] : '0;
      op_l = s1_first_q ? '0 : s1_op_q[i*ACC_W +: ACC_W];
      sum_vec[i*ACC_W +: ACC_W] = sat_add(op_l, in_l);
    end
  end

  // A stripe of length 1 re-reads the atom S2 is writing this very cycle.
  assign s1_op_d = (wr_en && (s1_idx_q == cur_idx)) ? sum_vec : stripe_mem_q[cur_idx];

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      atom_idx_q  <= '0;
      first_grp_q <= 1'b1;
      s1_vld_q    <= 1'b0;
      s1_ce_q     <= 1'b0;
      s1_le_q     <= 1'b0;
      s1_first_q  <= 1'b1;
      s1_idx_q    <= '0;
      s1_mask_q   <= '0;
      s1_data_q   <= '0;
      s1_op_q     <= '0;
    end else begin
      atom_idx_q  <= atom_idx_d;
      first_grp_q <= first_grp_d;
      s1_vld_q    <= mac2accu_pvld;
      if (mac2accu_pvld) begin
        s1_ce_q    <= beat_ce;
        s1_le_q    <= beat_le;
        s1_first_q <= first_grp_q;
        s1_idx_q   <= cur_idx;
        s1_mask_q  <= mac2accu_mask;
        s1_data_q  <= mac2accu_data;
        s1_op_q    <= s1_op_d;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) begin
      stripe_mem_q[s1_idx_q] <= sum_vec;
    end
  end

  // Output FIFO
  logic [DataW-1:0] fifo_data_q [OUT_DEPTH];
  logic [LANES-1:0] fifo_mask_q [OUT_DEPTH];
  logic             fifo_le_q   [OUT_DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             pop, full, push_ok, fifo_ovf;

  assign pop      = acc2out_pvld && acc2out_prdy;
  assign full     = (count_q == CntFull);
  assign push_ok  = push && (!full || pop);
  assign fifo_ovf = push && full && !pop;

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = cnt_t'(count_q + 1'b1);
      2'b01:   count_d = cnt_t'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_mask_q[i] <= '0;
        fifo_le_q[i]   <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        fifo_data_q[wr_ptr_q] <= sum_vec;
        fifo_mask_q[wr_ptr_q] <= s1_mask_q;
        fifo_le_q[wr_ptr_q]   <= s1_le_q;
      end
    end
  end

  assign acc2out_pvld      = (count_q != '0);
  assign acc2out_data      = fifo_data_q[rd_ptr_q];
  assign acc2out_mask      = fifo_mask_q[rd_ptr_q];
  assign acc2out_layer_end = fifo_le_q[rd_ptr_q];

  // Sticky error flags; a fresh error wins over a simultaneous clear.
  logic err_fifo_ovf_q, err_fifo_ovf_d;
  logic err_stripe_ovf_q, err_stripe_ovf_d;
  logic err_mode_q, err_mode_d;

  always_comb begin
    err_fifo_ovf_d   = (err_fifo_ovf_q && !err_clr) || fifo_ovf;
    err_stripe_ovf_d = (err_stripe_ovf_q && !err_clr) || stripe_ovf;
    err_mode_d       = (err_mode_q && !err_clr) || (mac2accu_pvld && mac2accu_mode);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      err_fifo_ovf_q   <= 1'b0;
      err_stripe_ovf_q <= 1'b0;
      err_mode_q       <= 1'b0;
    end else begin
      err_fifo_ovf_q   <= err_fifo_ovf_d;
      err_stripe_ovf_q <= err_stripe_ovf_d;
      err_mode_q       <= err_mode_d;
    end
  end

  assign err_fifo_ovf   = err_fifo_ovf_q;
  assign err_stripe_ovf = err_stripe_ovf_q;
  assign err_mode       = err_mode_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_psum_accum.sv
// Scoreboard bench for the partial-sum accumulator: stimulus pushes expected atoms,
// a negedge monitor pops and compares on every output handshake.
module tb_nv_nvdla_cacc_psum_accum;

  localparam int LANES      = 8;
  localparam int IN_W       = 19;
  localparam int ACC_W      = 20;
  localparam int STRIPE_MAX = 32;
  localparam int OUT_DEPTH  = 4;
  localparam int DW         = LANES * ACC_W;

  localparam logic [3:0] ST = 4'b0001;
  localparam logic [3:0] SE = 4'b0010;
  localparam logic [3:0] CE = 4'b0100;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  pvld;
  logic [LANES-1:0]      in_mask;
  logic                  in_mode;
  logic [LANES*IN_W-1:0] in_data;
  logic [8:0]            in_pd;
  logic                  out_pvld;
  logic                  out_prdy;
  logic [DW-1:0]         out_data;
  logic [LANES-1:0]      out_mask;
  logic                  out_le;
  logic                  err_clr;
  logic                  err_fifo_ovf, err_stripe_ovf, err_mode;

  nv_nvdla_cacc_psum_accum #(
    .LANES     (LANES),
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .STRIPE_MAX(STRIPE_MAX),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .mac2accu_pvld    (pvld),
    .mac2accu_mask    (in_mask),
    .mac2accu_mode    (in_mode),
    .mac2accu_data    (in_data),
    .mac2accu_pd      (in_pd),
    .acc2out_pvld     (out_pvld),
    .acc2out_prdy     (out_prdy),
    .acc2out_data     (out_data),
    .acc2out_mask     (out_mask),
    .acc2out_layer_end(out_le),
    .err_clr          (err_clr),
    .err_fifo_ovf     (err_fifo_ovf),
    .err_stripe_ovf   (err_stripe_ovf),
    .err_mode         (err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [LANES-1:0] mask;
    logic             le;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   fails     = 0;
  int   pops      = 0;
  int   cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [LANES*IN_W-1:0] din(input int a, input int b);
    logic [LANES*IN_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'((i == 0) ? a : b);
    return r;
  endfunction

  function automatic logic [DW-1:0] dexp(input int a, input int b, input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = m[i] ? ACC_W'((i == 0) ? a : b) : '0;
    return r;
  endfunction

  // kind: 0 = expect output, 1 = expect output with T+2 latency, 2 = output is dropped
  task automatic beat(input int a, input int b, input logic [LANES-1:0] m, input logic [3:0] fl,
                      input logic mode, input int ea, input int eb, input int kind);
    exp_t e;
    pvld    = 1'b1;
    in_mask = m;
    in_data = din(a, b);
    in_pd   = {5'b0, fl};
    in_mode = mode;
    if (fl[2] && kind != 2) begin
      e.data = dexp(ea, eb, m);
      e.mask = m;
      e.le   = fl[3];
      e.due  = (kind == 1) ? cyc + 2 : 0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    pvld    = 1'b0;
    in_mode = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (exp_q.size() != 0) check(name, DW'(exp_q.size()), '0);
  endtask

  always @(negedge clk) begin
    if (rstn && out_pvld && out_prdy) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_mask", DW'(out_mask), DW'(mon_e.mask));
        check("out_layer_end", DW'(out_le), DW'(mon_e.le));
        if (mon_e.due != 0) check("latency", DW'(cyc), DW'(mon_e.due));
      end
    end
  end

  initial begin
    int pops0;
    rstn = 1'b0; pvld = 1'b0; in_mask = '0; in_mode = 1'b0; in_data = '0; in_pd = '0;
    out_prdy = 1'b0; err_clr = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(1);
    check("reset_pvld", DW'(out_pvld), '0);
    check("reset_data", out_data, '0);
    check("reset_errs", DW'({err_fifo_ovf, err_stripe_ovf, err_mode}), '0);

    out_prdy = 1'b1;
    // 1: two-atom stripe, single group
    beat(5, 10, '1, ST | CE, 1'b0, 5, 10, 1);
    beat(-3, -6, '1, SE | CE, 1'b0, -3, -6, 1);
    drain("t1_drain");

    // 2: three atoms, two groups, partial mask
    beat(1, 4, 8'h05, ST, 1'b0, 0, 0, 0);
    beat(2, 4, 8'h05, 4'b0, 1'b0, 0, 0, 0);
    beat(3, 4, 8'h05, SE, 1'b0, 0, 0, 0);
    beat(10, 4, 8'h05, ST | CE, 1'b0, 11, 8, 1);
    beat(20, 4, 8'h05, CE, 1'b0, 22, 8, 1);
    beat(30, 4, 8'h05, SE | CE, 1'b0, 33, 8, 1);
    drain("t2_drain");

    // 3: stripe of length 1, back-to-back groups
    for (int i = 0; i < 3; i++) beat(7, 7, '1, ST | SE, 1'b0, 0, 0, 0);
    beat(7, 7, '1, ST | SE | CE, 1'b0, 28, 28, 1);
    drain("t3_drain");

    // 4: saturation both ways
    for (int i = 0; i < 2; i++) beat(262143, 262143, '1, ST | SE, 1'b0, 0, 0, 0);
    beat(262143, 262143, '1, ST | SE | CE, 1'b0, 524287, 524287, 1);
    for (int i = 0; i < 2; i++) beat(-262144, -262144, '1, ST | SE, 1'b0, 0, 0, 0);
    beat(-262144, -262144, '1, ST | SE | CE, 1'b0, -524288, -524288, 1);
    drain("t4_drain");

    // 5: FIFO overflow under backpressure
    out_prdy = 1'b0;
    for (int k = 1; k <= 5; k++) beat(k, k, '1, ST | SE | CE, 1'b0, k, k, (k == 5) ? 2 : 0);
    idle(3);
    check("t5_pvld", DW'(out_pvld), DW'(1));
    check("t5_head", out_data, dexp(1, 1, '1));
    check("t5_fifo_ovf", DW'(err_fifo_ovf), DW'(1));
    idle(2);
    check("t5_head_held", out_data, dexp(1, 1, '1));
    pops0 = pops;
    out_prdy = 1'b1;
    drain("t5_drain");
    idle(3);
    check("t5_pop_count", DW'(pops - pops0), DW'(4));
    check("t5_pvld_after", DW'(out_pvld), '0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("err_clr", DW'(err_fifo_ovf), '0);

    // mode=1 beat processed as direct
    beat(3, 3, '1, ST | SE | CE, 1'b1, 3, 3, 1);
    drain("mode_drain");
    check("err_mode", DW'(err_mode), DW'(1));

    // stripe overflow at the last index
    for (int i = 0; i < STRIPE_MAX - 1; i++) beat(1, 1, '1, (i == 0) ? ST : 4'b0, 1'b0, 0, 0, 0);
    idle(1);
    check("stripe_ovf_pre", DW'(err_stripe_ovf), '0);
    beat(1, 1, '1, 4'b0, 1'b0, 0, 0, 0);
    idle(1);
    check("stripe_ovf", DW'(err_stripe_ovf), DW'(1));

    // 6: reset mid-stripe discards partial sums
    beat(100, 100, '1, ST, 1'b0, 0, 0, 0);
    beat(200, 200, '1, SE, 1'b0, 0, 0, 0);
    idle(2);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    check("t6_errs", DW'({err_fifo_ovf, err_stripe_ovf, err_mode}), '0);
    check("t6_pvld", DW'(out_pvld), '0);
    beat(9, 9, '1, ST | SE | CE, 1'b0, 9, 9, 1);
    drain("t6_drain");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
